memory_cycle: RTL

- MEM stage of the 5-stage RV32I pipeline: holds the data memory and the MEM/WB pipeline register.
- Takes the EX/MEM stage outputs, performs loads and stores with RV32I byte, halfword and word sizes, and registers results toward the writeback stage.
- Outputs ALU_ResultW, ReadDataW, PCPlus4W and ResultSrcW feed the writeback result mux directly. RegWriteW and RD_W go to the register file and hazard unit.

---
 rtl/memory_cycle.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/memory_cycle.sv
// memory_cycle: MEM stage of a 5-stage RV32I pipeline.
// Holds the byte-addressable data memory (word-organised, DEPTH x 32 bits)
// and the MEM/WB pipeline register. Loads read combinationally during the
// cycle and the extended result is registered toward writeback. Stores
// update memory on the rising edge. Misaligned accesses are silently
// neutralised: stores are dropped and loads return zero.

module memory_cycle #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        ResultSrcM,
  input  logic [2:0]  funct3M,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] ALU_ResultM,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW
);

  // funct3 encodings for access size and signedness
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // ---------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------

  // Halfword accesses need an even offset, word accesses offset zero.
  // Byte accesses and unknown sizes are never flagged here.
  function automatic logic f_misaligned(input logic [2:0] f3,
                                        input logic [1:0] off);
    logic mis;
    case (f3)
      F3_H, F3_HU: mis = off[0];
      F3_W:        mis = (off != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Byte-lane enables for a store. Unknown sizes and misaligned accesses
  // yield an empty mask so the memory word is left untouched.
  function automatic logic [3:0] f_store_be(input logic [2:0] f3,
                                            input logic [1:0] off);
    logic [3:0] be;
    if (f_misaligned(f3, off)) begin
      be = 4'b0000;
    end else begin
      case (f3)
        F3_B:    be = 4'b0001 << off;
        F3_H:    be = off[1] ? 4'b1100 : 4'b0011;
        F3_W:    be = 4'b1111;
        default: be = 4'b0000;
      endcase
    end
    return be;
  endfunction

  // Replicate store data across lanes so the enable mask alone picks
  // the destination bytes.
  function automatic logic [31:0] f_store_data(input logic [2:0]  f3,
                                               input logic [31:0] wd);
    logic [31:0] d;
    case (f3)
      F3_B:    d = {4{wd[7:0]}};
      F3_H:    d = {2{wd[15:0]}};
      F3_W:    d = wd;
      default: d = 32'h0000_0000;
    endcase
    return d;
  endfunction

  // Merge new lanes into the existing word under a byte-enable mask.
  function automatic logic [31:0] f_merge(input logic [31:0] old_word,
                                          input logic [31:0] new_data,
                                          input logic [3:0]  be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = be[b] ? new_data[8*b +: 8] : old_word[8*b +: 8];
    end
    return m;
  endfunction

  // Lane selection plus sign/zero extension for loads. Misaligned loads
  // and unknown sizes return zero.
  function automatic logic [31:0] f_load_ext(input logic [31:0] word,
                                             input logic [2:0]  f3,
                                             input logic [1:0]  off);
    logic [7:0]  bsel;
    logic [15:0] hsel;
    logic [31:0] res;
    case (off)
      2'b00:   bsel = word[7:0];
      2'b01:   bsel = word[15:8];
      2'b10:   bsel = word[23:16];
      default: bsel = word[31:24];
    endcase
    hsel = off[1] ? word[31:16] : word[15:0];
    if (f_misaligned(f3, off)) begin
      res = 32'h0000_0000;
    end else begin
      case (f3)
        F3_B:    res = {{24{bsel[7]}}, bsel};
        F3_BU:   res = {24'h00_0000, bsel};
        F3_H:    res = {{16{hsel[15]}}, hsel};
        F3_HU:   res = {16'h0000, hsel};
        F3_W:    res = word;
        default: res = 32'h0000_0000;
      endcase
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------
  // Address decode and datapath
  // ---------------------------------------------------------------------

  // Upper address bits are dropped so accesses wrap modulo DEPTH*4 bytes.
  logic [AW-1:0] w_idx;
  logic [1:0]    w_off;
  logic [31:0]   w_mem [DEPTH];
  logic [31:0]   w_rd_word;
  logic [31:0]   w_load_val;
  logic [3:0]    w_be;
  logic [31:0]   w_st_data;
  logic [31:0]   w_wr_word;

  assign w_idx = ALU_ResultM[AW+1:2];
  assign w_off = ALU_ResultM[1:0];

  // Read side sees the word as it stands before this edge's store, which
  // is what gives the pre-store value when a store and load coincide.
  assign w_rd_word  = w_mem[w_idx];
  assign w_load_val = f_load_ext(w_rd_word, funct3M, w_off);

  assign w_be      = MemWriteM ? f_store_be(funct3M, w_off) : 4'b0000;
  assign w_st_data = f_store_data(funct3M, WriteDataM);
  assign w_wr_word = f_merge(w_rd_word, w_st_data, w_be);

  // ---------------------------------------------------------------------
  // Data memory: one register per word so reset can clear every entry
  // ---------------------------------------------------------------------
  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    logic r_word;
    logic [31:0] r_data;
    logic        w_we;

    assign w_we     = (w_be != 4'b0000) && (w_idx == AW'(g));
    assign w_mem[g] = r_data;

    // Hold the word, take the merged value when this word is the target.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_data <= 32'h0000_0000;
      end else if (w_we) begin
        r_data <= w_wr_word;
      end else begin
        r_data <= r_data;
      end
    end
  end

  // ---------------------------------------------------------------------
  // MEM/WB pipeline register: updates every edge, no stall or flush
  // ---------------------------------------------------------------------
  logic        r_reg_write;
  logic        r_result_src;
  logic [4:0]  r_rd;
  logic [31:0] r_pc_plus4;
  logic [31:0] r_alu_result;
  logic [31:0] r_read_data;

  // Capture the M-stage controls and the extended load value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_reg_write  <= 1'b0;
      r_result_src <= 1'b0;
      r_rd         <= 5'd0;
      r_pc_plus4   <= 32'h0000_0000;
      r_alu_result <= 32'h0000_0000;
      r_read_data  <= 32'h0000_0000;
    end else begin
      r_reg_write  <= RegWriteM;
      r_result_src <= ResultSrcM;
      r_rd         <= RD_M;
      r_pc_plus4   <= PCPlus4M;
      r_alu_result <= ALU_ResultM;
      r_read_data  <= w_load_val;
    end
  end

  assign RegWriteW   = r_reg_write;
  assign ResultSrcW  = r_result_src;
  assign RD_W        = r_rd;
  assign PCPlus4W    = r_pc_plus4;
  assign ALU_ResultW = r_alu_result;
  assign ReadDataW   = r_read_data;

endmodule
